histogram_runner: RTL and testbench
===================================

# histogram_runner

Run-level sequencer for the `histogram_hls` kernel. It loads the input buffer A from a sample stream, clears result buffer B, and launches the kernel with an ap_ctrl_hs handshake. It then drains B onto a result stream. It owns the single ports of both buffer RAMs and muxes each between its own load/clear/drain engines and the kernel. The kernel's `A_q0` is wired directly from RAM A.

## Interface
- `ADDR_W`, 8: RAM address width; A and B depth is 2^ADDR_W.
- `A_DATA_W`, 8: sample width.
- `B_DATA_W`, 32: bin count width.
- `N_ELEMS`, 256: samples per run, 1..2^ADDR_W.
- `N_BINS`, 256: bins cleared and drained, 1..2^ADDR_W.
- `ap_clk` in 1: single clock; all logic on its rising edge.
- `ap_rst` in 1: asynchronous, active-high reset.
- `start` in 1, `busy` out 1, `done` out 1: run control.
- `s_data` in A_DATA_W, `s_valid` in 1, `s_ready` out 1: sample stream.
- `m_data` out B_DATA_W, `m_bin` out ADDR_W, `m_valid` out 1, `m_ready` in 1: result stream.
- `k_ap_start` out 1, `k_ap_done` in 1, `k_ap_ready` in 1, `k_ap_idle` in 1: kernel control.
- `k_A_address0` in ADDR_W, `k_A_ce0` in 1: kernel A read request.
- `k_B_address0` in ADDR_W, `k_B_ce0` in 1, `k_B_we0` in 1, `k_B_d0` in B_DATA_W: kernel B request.
- `a_address0` out ADDR_W, `a_ce0` out 1, `a_we0` out 1, `a_d0` out A_DATA_W: RAM A port.
- `b_address0` out ADDR_W, `b_ce0` out 1, `b_we0` out 1, `b_d0` out B_DATA_W, `b_q0` in B_DATA_W: RAM B port; read data valid one cycle after `ce`.

## Operation
- States: IDLE, LOAD, CLEAR, KSTART, KWAIT, DRN_RD, DRN_CAP, DRN_OUT, DONE.
- One counter `cnt`, ADDR_W+1 bits. It is cleared on every state entry.
- IDLE: `start`=1 moves the FSM to LOAD. `start` is ignored in all other states.
- LOAD:
  - `s_ready`=1, combinational on state.
  - Each `s_valid`&`s_ready` beat drives a write in the same cycle: `a_ce0`=`a_we0`=1, `a_address0`=`cnt`, `a_d0`=`s_data`. `cnt` then increments.
  - After beat N_ELEMS-1 is accepted, the FSM moves to CLEAR.
- CLEAR: one cycle per bin with `b_ce0`=`b_we0`=1, `b_d0`=0, `b_address0`=`cnt`. After N_BINS cycles, the FSM moves to KSTART.
- KSTART: `k_ap_start`=1 until `k_ap_ready` is sampled high.
  - `k_ap_ready` alone moves the FSM to KWAIT.
  - `k_ap_ready` and `k_ap_done` together move the FSM to DRN_RD.
- KWAIT: `k_ap_done`=1 moves the FSM to DRN_RD.
- Kernel mux, active in KSTART and KWAIT only:
  - RAM A: `a_address0`=`k_A_address0`, `a_ce0`=`k_A_ce0`, `a_we0`=0, `a_d0`=0.
  - RAM B: all four B outputs follow the `k_B_*` inputs.
- Drain, per bin `cnt`:
  - DRN_RD: `b_ce0`=1, `b_we0`=0, `b_address0`=`cnt`.
  - DRN_CAP: `m_data` register loads `b_q0`; `m_bin` register loads `cnt`.
  - DRN_OUT: `m_valid`=1 until `m_ready`. On the handshake, `cnt` increments and the FSM goes to DRN_RD, or to DONE after bin N_BINS-1.
- DONE: `done`=1 for one cycle, then IDLE.
- `busy`=1 in every state except IDLE.
- Outside their owning states, all RAM `ce`/`we` outputs are 0 and addresses and data are 0.
- `k_ap_done` and `k_ap_ready` are ignored outside KSTART and KWAIT. `k_ap_idle` is informational only and does not change the FSM.

## Timing
- Reset values: state IDLE, `cnt`=0; every output is 0, including `busy`, `done`, `s_ready`, `m_valid`, `m_data`, `m_bin`, `k_ap_start`, and all RAM strobes, addresses and data.
- Reset mid-run: asynchronous return to IDLE with all outputs 0 immediately. RAM contents are then undefined. The kernel shares `ap_rst`.
- `start` high at edge t makes `busy` and `s_ready` 1 after edge t.
- LOAD takes N_ELEMS accepted beats; input gaps stall `cnt` and write nothing.
- CLEAR takes exactly N_BINS cycles.
- KSTART takes at least 1 cycle.
- Drain takes at least 3 cycles per bin. `m_data` and `m_bin` are stable while `m_valid`=1 and `m_ready`=0.
- Best-case run is N_ELEMS + N_BINS + kernel latency + 3·N_BINS + 2 cycles, from `start` to the `done` pulse.

## Test plan
- Reset: assert `ap_rst` mid-LOAD → all outputs 0 at once. After deassert, `start` → `s_ready`=1 on the next cycle and a full run passes.
- Full run with the behavioural kernel and 256 samples of value 5 → 256 result beats, bins 0..255 in order; bin 5 = 256, all others 0; one `done` pulse; `busy` returns to 0.
- Sample stream with `s_valid` toggling every cycle → LOAD lasts 512 cycles; RAM A writes hit addresses 0..255 contiguously, each exactly once.
- `m_ready` held low 10 cycles at bin 3 → `m_valid`=1 with `m_bin`=3 and `m_data` stable; the next RAM B read is issued only after the handshake.
- Kernel stub asserting `k_ap_ready` and `k_ap_done` in the same cycle → KWAIT skipped; DRN_RD next. A `start` pulse during drain → no effect.
- During CLEAR, kernel stub drives `k_B_we0`=1 → RAM B shows only the clear writes. During KWAIT, `b_*` follows `k_B_*` exactly.

Source files
------------

// File: rtl/histogram_runner.sv
// histogram_runner: run-level sequencer around the histogram_hls kernel.
// Loads RAM A from a sample stream, clears RAM B, launches the kernel with an
// ap_ctrl_hs handshake, then drains RAM B onto a result stream. Owns the
// single ports of both RAMs and hands them to the kernel while it runs.
module histogram_runner #(
  parameter int ADDR_W   = 8,
  parameter int A_DATA_W = 8,
  parameter int B_DATA_W = 32,
  parameter int N_ELEMS  = 256,
  parameter int N_BINS   = 256
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  // run control
  input  logic                start,
  output logic                busy,
  output logic                done,
  // sample stream
  input  logic [A_DATA_W-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  // result stream
  output logic [B_DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0]   m_bin,
  output logic                m_valid,
  input  logic                m_ready,
  // kernel control
  output logic                k_ap_start,
  input  logic                k_ap_done,
  input  logic                k_ap_ready,
  input  logic                k_ap_idle,
  // kernel RAM requests
  input  logic [ADDR_W-1:0]   k_A_address0,
  input  logic                k_A_ce0,
  input  logic [ADDR_W-1:0]   k_B_address0,
  input  logic                k_B_ce0,
  input  logic                k_B_we0,
  input  logic [B_DATA_W-1:0] k_B_d0,
  // RAM A port
  output logic [ADDR_W-1:0]   a_address0,
  output logic                a_ce0,
  output logic                a_we0,
  output logic [A_DATA_W-1:0] a_d0,
  // RAM B port
  output logic [ADDR_W-1:0]   b_address0,
  output logic                b_ce0,
  output logic                b_we0,
  output logic [B_DATA_W-1:0] b_d0,
  input  logic [B_DATA_W-1:0] b_q0
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LOAD    = 4'd1,
    S_CLEAR   = 4'd2,
    S_KSTART  = 4'd3,
    S_KWAIT   = 4'd4,
    S_DRN_RD  = 4'd5,
    S_DRN_CAP = 4'd6,
    S_DRN_OUT = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  localparam logic [ADDR_W:0] LAST_ELEM = (ADDR_W+1)'(N_ELEMS - 1);
  localparam logic [ADDR_W:0] LAST_BIN  = (ADDR_W+1)'(N_BINS - 1);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);

  // Low ADDR_W bits of the counter drive the RAM addresses.
  function automatic logic [ADDR_W-1:0] cnt_addr(input logic [ADDR_W:0] c);
    return c[ADDR_W-1:0];
  endfunction

  state_t                state_q, state_d;
  logic [ADDR_W:0]       cnt_q, cnt_d;
  logic [B_DATA_W-1:0]   m_data_q, m_data_d;
  logic [ADDR_W-1:0]     m_bin_q, m_bin_d;

  // k_ap_idle is status only; it never steers the sequencer.
  logic unused_s;
  assign unused_s = &{1'b0, k_ap_idle};

  // Next-state, counter and result-register update logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    m_data_d = m_data_q;
    m_bin_d  = m_bin_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        // s_ready is high throughout LOAD, so s_valid alone is a beat.
        if (s_valid) begin
          if (cnt_q == LAST_ELEM) begin
            state_d = S_CLEAR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_CLEAR: begin
        if (cnt_q == LAST_BIN) begin
          state_d = S_KSTART;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_KSTART: begin
        // A kernel that finishes in the accepting cycle skips KWAIT.
        if (k_ap_ready && k_ap_done) begin
          state_d = S_DRN_RD;
          cnt_d   = '0;
        end else if (k_ap_ready) begin
          state_d = S_KWAIT;
          cnt_d   = '0;
        end else begin
          state_d = S_KSTART;
        end
      end
      S_KWAIT: begin
        if (k_ap_done) begin
          state_d = S_DRN_RD;
          cnt_d   = '0;
        end else begin
          state_d = S_KWAIT;
        end
      end
      S_DRN_RD: begin
        state_d = S_DRN_CAP;
      end
      S_DRN_CAP: begin
        // RAM B read data is valid one cycle after the DRN_RD request.
        m_data_d = b_q0;
        m_bin_d  = cnt_addr(cnt_q);
        state_d  = S_DRN_OUT;
      end
      S_DRN_OUT: begin
        if (m_ready) begin
          if (cnt_q == LAST_BIN) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            state_d = S_DRN_RD;
            cnt_d   = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = S_DRN_OUT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencer state, counter and result registers.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      m_data_q <= '0;
      m_bin_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      m_data_q <= m_data_d;
      m_bin_q  <= m_bin_d;
    end
  end

  assign m_data = m_data_q;
  assign m_bin  = m_bin_q;

  // Control outputs and RAM port muxing, decoded from the registered state.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    k_ap_start = 1'b0;
    a_address0 = '0;
    a_ce0      = 1'b0;
    a_we0      = 1'b0;
    a_d0       = '0;
    b_address0 = '0;
    b_ce0      = 1'b0;
    b_we0      = 1'b0;
    b_d0       = '0;
    if (state_q != S_IDLE) begin
      busy = 1'b1;
    end else begin
      busy = 1'b0;
    end
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_LOAD: begin
        s_ready = 1'b1;
        // Gaps in the stream write nothing.
        if (s_valid) begin
          a_ce0      = 1'b1;
          a_we0      = 1'b1;
          a_address0 = cnt_addr(cnt_q);
          a_d0       = s_data;
        end else begin
          a_ce0 = 1'b0;
          a_we0 = 1'b0;
        end
      end
      S_CLEAR: begin
        b_ce0      = 1'b1;
        b_we0      = 1'b1;
        b_address0 = cnt_addr(cnt_q);
        b_d0       = '0;
      end
      S_KSTART, S_KWAIT: begin
        // Kernel owns both RAMs; it only ever reads A.
        k_ap_start = (state_q == S_KSTART);
        a_address0 = k_A_address0;
        a_ce0      = k_A_ce0;
        a_we0      = 1'b0;
        a_d0       = '0;
        b_address0 = k_B_address0;
        b_ce0      = k_B_ce0;
        b_we0      = k_B_we0;
        b_d0       = k_B_d0;
      end
      S_DRN_RD: begin
        b_ce0      = 1'b1;
        b_we0      = 1'b0;
        b_address0 = cnt_addr(cnt_q);
      end
      S_DRN_CAP: begin
        m_valid = 1'b0;
      end
      S_DRN_OUT: begin
        m_valid = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_histogram_runner.sv
// Directed testbench for histogram_runner with behavioural RAMs and a
// behavioural histogram kernel (k_mode=0) or a same-cycle ready/done stub
// that also tries to write RAM B outside its window (k_mode=1).
module tb_histogram_runner;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        start, busy, done;
  logic [7:0]  s_data;
  logic        s_valid, s_ready;
  logic [31:0] m_data;
  logic [7:0]  m_bin;
  logic        m_valid, m_ready;
  logic        k_ap_start, k_ap_done, k_ap_ready, k_ap_idle;
  logic [7:0]  k_A_address0;
  logic        k_A_ce0;
  logic [7:0]  k_B_address0;
  logic        k_B_ce0, k_B_we0;
  logic [31:0] k_B_d0;
  logic [7:0]  a_address0;
  logic        a_ce0, a_we0;
  logic [7:0]  a_d0;
  logic [7:0]  b_address0;
  logic        b_ce0, b_we0;
  logic [31:0] b_d0;
  logic [31:0] b_q0;

  always #5 ap_clk = ~ap_clk;

  histogram_runner dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .start(start), .busy(busy), .done(done),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_bin(m_bin), .m_valid(m_valid), .m_ready(m_ready),
    .k_ap_start(k_ap_start), .k_ap_done(k_ap_done), .k_ap_ready(k_ap_ready), .k_ap_idle(k_ap_idle),
    .k_A_address0(k_A_address0), .k_A_ce0(k_A_ce0),
    .k_B_address0(k_B_address0), .k_B_ce0(k_B_ce0), .k_B_we0(k_B_we0), .k_B_d0(k_B_d0),
    .a_address0(a_address0), .a_ce0(a_ce0), .a_we0(a_we0), .a_d0(a_d0),
    .b_address0(b_address0), .b_ce0(b_ce0), .b_we0(b_we0), .b_d0(b_d0), .b_q0(b_q0)
  );

  // ---------------- behavioural RAMs ----------------
  logic [7:0]  mem_a [256];
  logic [31:0] mem_b [256];
  logic [7:0]  a_q;

  always @(posedge ap_clk) begin
    if (a_ce0) begin
      if (a_we0) mem_a[a_address0] <= a_d0;
      a_q <= mem_a[a_address0];
    end
  end

  // RAM B contents become garbage while reset is held
  always @(posedge ap_clk) begin
    if (ap_rst) begin
      for (int i = 0; i < 256; i++) mem_b[i] <= 32'h0BAD_0000 + 32'(i);
    end else if (b_ce0) begin
      if (b_we0) mem_b[b_address0] <= b_d0;
      b_q0 <= mem_b[b_address0];
    end
  end

  // ---------------- behavioural kernel ----------------
  typedef enum logic [2:0] {K_IDLE, K_RDA, K_RDB, K_WRB, K_FIN} kst_t;
  kst_t       ks;
  logic [8:0] ki;
  logic [7:0] kbin;
  logic [3:0] stub_cnt;
  logic       k_mode;

  always @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      ks <= K_IDLE; ki <= 9'd0; kbin <= 8'd0; stub_cnt <= 4'd0;
    end else begin
      stub_cnt <= k_ap_start ? stub_cnt + 4'd1 : 4'd0;
      case (ks)
        K_IDLE: if (!k_mode && k_ap_start) begin ks <= K_RDA; ki <= 9'd0; end
        K_RDA:  ks <= K_RDB;
        K_RDB:  begin kbin <= a_q; ks <= K_WRB; end
        K_WRB:  if (ki == 9'd255) ks <= K_FIN; else begin ki <= ki + 9'd1; ks <= K_RDA; end
        K_FIN:  ks <= K_IDLE;
        default: ks <= K_IDLE;
      endcase
    end
  end

  always_comb begin
    k_ap_ready = 1'b0; k_ap_done = 1'b0; k_ap_idle = (ks == K_IDLE);
    k_A_address0 = 8'd0; k_A_ce0 = 1'b0;
    k_B_address0 = 8'd0; k_B_ce0 = 1'b0; k_B_we0 = 1'b0; k_B_d0 = 32'd0;
    if (k_mode) begin
      if (k_ap_start) begin
        if (stub_cnt == 4'd2) begin k_ap_ready = 1'b1; k_ap_done = 1'b1; end
      end else begin
        k_B_ce0 = 1'b1; k_B_we0 = 1'b1; k_B_address0 = 8'd5; k_B_d0 = 32'hDEAD_BEEF;
      end
    end else begin
      case (ks)
        K_IDLE: k_ap_ready = k_ap_start;
        K_RDA:  begin k_A_ce0 = 1'b1; k_A_address0 = ki[7:0]; end
        K_RDB:  begin k_B_ce0 = 1'b1; k_B_address0 = a_q; end
        K_WRB:  begin k_B_ce0 = 1'b1; k_B_we0 = 1'b1; k_B_address0 = kbin; k_B_d0 = b_q0 + 32'd1; end
        K_FIN:  k_ap_done = 1'b1;
        default: k_ap_idle = 1'b1;
      endcase
    end
  end

  // ---------------- result stream back-pressure ----------------
  int stall_req, stall_seen;
  assign m_ready = !(stall_seen < stall_req && m_valid && m_bin == 8'd3);

  // ---------------- monitors ----------------
  int          load_cyc, a_wr_cnt, a_wr_errs, beats, done_cnt;
  int          stall_errs, mux_errs, b_leak;
  logic [31:0] stall_data;
  logic [31:0] res_data [256];
  logic [7:0]  res_bin  [256];

  always @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      load_cyc <= 0; a_wr_cnt <= 0; a_wr_errs <= 0; beats <= 0; done_cnt <= 0;
      stall_seen <= 0; stall_errs <= 0; mux_errs <= 0; b_leak <= 0; stall_data <= 32'd0;
    end else begin
      if (s_ready) load_cyc <= load_cyc + 1;
      if (a_ce0 && a_we0) begin
        if (a_address0 !== a_wr_cnt[7:0] || a_d0 !== s_data) a_wr_errs <= a_wr_errs + 1;
        a_wr_cnt <= a_wr_cnt + 1;
      end
      if (m_valid && m_ready) begin
        res_bin[beats[7:0]]  <= m_bin;
        res_data[beats[7:0]] <= m_data;
        beats <= beats + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
      if (stall_seen < stall_req && m_valid && m_bin == 8'd3) begin
        stall_seen <= stall_seen + 1;
        if (stall_seen == 0) stall_data <= m_data;
        else if (m_data !== stall_data) stall_errs <= stall_errs + 1;
        if (b_ce0) stall_errs <= stall_errs + 1;
      end
      if (!k_mode && ks != K_IDLE) begin
        if ({a_address0, a_ce0, a_we0, a_d0, b_address0, b_ce0, b_we0, b_d0} !==
            {k_A_address0, k_A_ce0, 1'b0, 8'd0, k_B_address0, k_B_ce0, k_B_we0, k_B_d0})
          mux_errs <= mux_errs + 1;
      end
      if (k_mode && b_ce0 && b_we0 && b_d0 != 32'd0) b_leak <= b_leak + 1;
    end
  end

  logic [127:0] outs_s;
  assign outs_s = {23'd0, busy, done, s_ready, m_valid, m_data, m_bin, k_ap_start,
                   a_address0, a_ce0, a_we0, a_d0, b_address0, b_ce0, b_we0, b_d0};

  // ---------------- checking helpers ----------------
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 20000) begin
      @(negedge ap_clk);
      n++;
    end
    check({tag, "_busy_drops"}, 128'(busy), 128'(0));
  endtask

  // mode 1: only bin 5 = 256; mode 2: all zero; mode 3: bins 0..7 = 32
  task automatic check_bins(input string tag, input int mode);
    int bad = 0;
    logic [31:0] exp;
    for (int b = 0; b < 256; b++) begin
      if (mode == 1)      exp = (b == 5) ? 32'd256 : 32'd0;
      else if (mode == 3) exp = (b < 8)  ? 32'd32  : 32'd0;
      else                exp = 32'd0;
      if (res_bin[b] !== 8'(b) || res_data[b] !== exp) bad++;
    end
    check({tag, "_bins"}, 128'(bad), 128'(0));
  endtask

  int base_load, base_awr, base_beats, base_done;

  // ---------------- directed sequence ----------------
  initial begin
    ap_rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'd0; k_mode = 1'b0; stall_req = 0;
    repeat (3) @(negedge ap_clk);
    check("reset_outputs", outs_s, 128'(0));
    ap_rst = 1'b0;

    // reset in the middle of LOAD
    @(negedge ap_clk); start = 1'b1;
    @(negedge ap_clk); start = 1'b0;
    check("start_busy_sready", 128'({busy, s_ready}), 128'(2'b11));
    s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_data = 8'(i);
      @(negedge ap_clk);
    end
    check("midload_write", 128'({a_ce0, a_we0, a_address0, a_d0}), 128'({2'b11, 8'd10, 8'd9}));
    ap_rst = 1'b1;
    #1;
    check("reset_async_outputs", outs_s, 128'(0));
    @(negedge ap_clk); ap_rst = 1'b0; s_valid = 1'b0;

    // run 1: value 5, s_valid toggling, stall at bin 3, real kernel
    k_mode = 1'b0; stall_req = 10;
    base_load = load_cyc;
    @(negedge ap_clk); start = 1'b1;
    @(negedge ap_clk); start = 1'b0; s_valid = 1'b0;
    check("run1_sready", 128'(s_ready), 128'(1));
    for (int i = 0; i < 256; i++) begin
      @(negedge ap_clk); s_valid = 1'b1; s_data = 8'd5;
      @(negedge ap_clk); s_valid = 1'b0;
    end
    check("run1_load_cycles", 128'(load_cyc - base_load), 128'(512));
    check("run1_a_writes", 128'(a_wr_cnt), 128'(256));
    check("run1_a_order", 128'(a_wr_errs), 128'(0));
    begin
      int n = 0;
      while (stall_seen != 5 && n < 20000) begin
        @(negedge ap_clk);
        n++;
      end
    end
    check("run1_stall_reached", 128'(stall_seen), 128'(5));
    check("run1_stall_mvalid", 128'(m_valid), 128'(1));
    check("run1_stall_mbin", 128'(m_bin), 128'(3));
    check("run1_stall_mdata", 128'(m_data), 128'(0));
    check("run1_stall_no_read", 128'(b_ce0), 128'(0));
    wait_idle("run1");
    check("run1_done_pulses", 128'(done_cnt), 128'(1));
    check("run1_beats", 128'(beats), 128'(256));
    check_bins("run1", 1);
    check("run1_kernel_mux", 128'(mux_errs), 128'(0));
    check("run1_stall_stable", 128'(stall_errs), 128'(0));
    check("run1_stall_len", 128'(stall_seen), 128'(10));

    // run 2: stub kernel with same-cycle ready/done and stray B writes
    k_mode = 1'b1;
    base_load = load_cyc; base_awr = a_wr_cnt; base_beats = beats; base_done = done_cnt;
    @(negedge ap_clk); start = 1'b1;
    @(negedge ap_clk); start = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      s_data = 8'(255 - i);
      @(negedge ap_clk);
    end
    s_valid = 1'b0;
    check("run2_load_cycles", 128'(load_cyc - base_load), 128'(256));
    check("run2_a_writes", 128'(a_wr_cnt - base_awr), 128'(256));
    begin
      int n = 0;
      while (k_ap_start !== 1'b1 && n < 2000) begin
        @(negedge ap_clk);
        n++;
      end
    end
    check("run2_kstart_seen", 128'(k_ap_start), 128'(1));
    repeat (3) @(negedge ap_clk);
    check("run2_kwait_skipped", 128'({k_ap_start, b_ce0, b_we0, b_address0}), 128'({1'b0, 1'b1, 1'b0, 8'd0}));
    start = 1'b1;
    @(negedge ap_clk); start = 1'b0;
    wait_idle("run2");
    repeat (3) @(negedge ap_clk);
    check("run2_start_ignored", 128'({busy, s_ready}), 128'(0));
    check("run2_done_pulses", 128'(done_cnt - base_done), 128'(1));
    check("run2_beats", 128'(beats - base_beats), 128'(256));
    check_bins("run2", 2);
    check("run2_no_stray_b_writes", 128'(b_leak), 128'(0));
    check("run2_a_order", 128'(a_wr_errs), 128'(0));

    // run 3: values 0..7 repeating, contiguous stream, real kernel
    k_mode = 1'b0;
    base_load = load_cyc; base_beats = beats; base_done = done_cnt;
    @(negedge ap_clk); start = 1'b1;
    @(negedge ap_clk); start = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      s_data = 8'(i % 8);
      @(negedge ap_clk);
    end
    s_valid = 1'b0;
    check("run3_load_cycles", 128'(load_cyc - base_load), 128'(256));
    wait_idle("run3");
    check("run3_done_pulses", 128'(done_cnt - base_done), 128'(1));
    check("run3_beats", 128'(beats - base_beats), 128'(256));
    check_bins("run3", 3);
    check("run3_kernel_mux", 128'(mux_errs), 128'(0));
    check("run3_a_order", 128'(a_wr_errs), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
